// File: rtl/command_credit_scheduler_if.sv
// Command-line types and the scheduler's requester/command-slot interface.
// The package comes first so that the interface and the scheduler can both import it.
package command_credit_pkg;

  typedef enum logic [7:0] {
    INVALID    = 8'h00,
    RESTART    = 8'h01,
    READ_CL_NA = 8'h0A,
    WRITE_NA   = 8'h0D
  } command_t;

  typedef enum logic [2:0] {
    STRICT = 3'd0,
    ABORT  = 3'd1,
    PAGE   = 3'd2,
    PREF   = 3'd3,
    SPEC   = 3'd4
  } abt_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cmd;
    command_t    command;
    logic [63:0] address;
    logic [11:0] size;
    abt_t        abt;
  } CommandBufferLine;

  localparam CommandBufferLine CMD_LINE_RESET = '{
    valid:   1'b0,
    cmd:     8'h00,
    command: INVALID,
    address: 64'h0,
    size:    12'h000,
    abt:     STRICT
  };

endpackage

interface command_credit_sched_if #(
  parameter int NUM_REQUESTS = 4
);
  import command_credit_pkg::*;

  CommandBufferLine        command_buffer_in [NUM_REQUESTS];
  logic [NUM_REQUESTS-1:0] requests;
  logic                    credit_return;
  CommandBufferLine        command_arbiter_out;
  logic [NUM_REQUESTS-1:0] ready;

  // Master is the requester/response side; slave is the scheduler.
  modport master (
    output command_buffer_in, requests, credit_return,
    input  command_arbiter_out, ready
  );

  modport slave (
    input  command_buffer_in, requests, credit_return,
    output command_arbiter_out, ready
  );

endinterface

// File: rtl/command_credit_scheduler.sv
// Credit-aware round-robin scheduler for the AFU command slot, with enable-driven start-up and drain.
// Optional issue counter: define CMD_SCHED_ISSUE_COUNT_EN to build issue_count, else it is tied to 0.
module command_credit_scheduler
  import command_credit_pkg::*;
#(
  parameter int NUM_REQUESTS = 4,
  parameter int CREDIT_W     = 8
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                enabled_in,
  input  logic [CREDIT_W-1:0] credits_init,
  command_credit_sched_if.slave cmd_if,
  output logic [CREDIT_W-1:0] credits_available,
  output logic [CREDIT_W-1:0] outstanding,
  output logic                credit_error,
  output logic                drained,
  output logic [31:0]         issue_count
);

  localparam int PTR_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_enabled;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CREDIT_W-1:0] r_credits;
  logic [CREDIT_W-1:0] r_outstanding;
  logic               r_credit_error;
  CommandBufferLine   r_cmd_out;

  logic                    w_grant;
  logic [PTR_W-1:0]        w_winner;
  logic [NUM_REQUESTS-1:0] w_ready;
  logic                    w_return;
  logic [CREDIT_W-1:0]     w_credits_next;
  logic [CREDIT_W-1:0]     w_outstanding_next;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQUESTS) sum = sum - NUM_REQUESTS;
    return PTR_W'(sum);
  endfunction

  // NOTE: pure synchronizer-style stage with no control meaning of its own, so it carries no reset.
  always_ff @(posedge clock) begin
    r_enabled <= enabled_in;
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (r_enabled) w_state_next = ST_INIT;
      ST_INIT:  w_state_next = ST_RUN;
      ST_RUN:   if (!r_enabled) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (r_enabled)                w_state_next = ST_RUN;
        else if (r_outstanding == '0) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    w_ready  = '0;
    if (r_state == ST_RUN && r_credits != '0) begin
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        if (!w_grant && cmd_if.requests[rr_index(r_rr_ptr, i)]) begin
          w_grant  = 1'b1;
          w_winner = rr_index(r_rr_ptr, i);
        end
      end
    end
    if (w_grant) w_ready[w_winner] = 1'b1;
  end

  // A return with nothing outstanding is flagged but never touches the counters.
  assign w_return = cmd_if.credit_return && (r_outstanding != '0);

  always_comb begin
    w_credits_next     = r_credits;
    w_outstanding_next = r_outstanding;
    unique case (r_state)
      ST_IDLE: begin
        if (w_return) w_outstanding_next = r_outstanding - CREDIT_W'(1);
      end
      ST_INIT: begin
        w_credits_next = credits_init;
        if (w_return) w_outstanding_next = r_outstanding - CREDIT_W'(1);
      end
      default: begin
        if (w_grant && !w_return) begin
          w_credits_next = r_credits - CREDIT_W'(1);
          if (r_outstanding != '1) w_outstanding_next = r_outstanding + CREDIT_W'(1);
        end else if (!w_grant && w_return) begin
          if (r_credits != '1) w_credits_next = r_credits + CREDIT_W'(1);
          w_outstanding_next = r_outstanding - CREDIT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_credits      <= '0;
      r_outstanding  <= '0;
      r_rr_ptr       <= '0;
      r_credit_error <= 1'b0;
      r_cmd_out      <= CMD_LINE_RESET;
    end else begin
      r_credits     <= w_credits_next;
      r_outstanding <= w_outstanding_next;
      if (w_grant) r_rr_ptr <= rr_index(w_winner, 1);
      if (cmd_if.credit_return && r_outstanding == '0) r_credit_error <= 1'b1;
      r_cmd_out <= w_grant ? cmd_if.command_buffer_in[w_winner] : CMD_LINE_RESET;
    end
  end

`ifdef CMD_SCHED_ISSUE_COUNT_EN
  logic [31:0] r_issue_count;

  always_ff @(posedge clock) begin
    if (!rstn)                                               r_issue_count <= '0;
    else if (r_state == ST_IDLE && w_state_next == ST_INIT)  r_issue_count <= '0;
    else if (w_grant)                                        r_issue_count <= r_issue_count + 32'd1;
  end

  assign issue_count = r_issue_count;
`else
  assign issue_count = '0;
`endif

  assign cmd_if.ready               = w_ready;
  assign cmd_if.command_arbiter_out = r_cmd_out;
  assign credits_available          = r_credits;
  assign outstanding                = r_outstanding;
  assign credit_error               = r_credit_error;
  assign drained                    = (r_state == ST_IDLE) && (r_outstanding == '0);

endmodule

// File: tb/tb_command_credit_scheduler.sv
// Directed bench for command_credit_scheduler: reset, round-robin, credits, drain, error and issue count.
module tb_command_credit_scheduler;
  import command_credit_pkg::*;

`ifdef CMD_SCHED_ISSUE_COUNT_EN
  localparam bit ISSUE_EN = 1'b1;
`else
  localparam bit ISSUE_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rstn;
  logic        enabled_in;
  logic [7:0]  credits_init;
  logic [7:0]  credits_available;
  logic [7:0]  outstanding;
  logic        credit_error;
  logic        drained;
  logic [31:0] issue_count;

  int n_checks = 0;
  int n_bad    = 0;

  CommandBufferLine lines [4];

  command_credit_sched_if #(.NUM_REQUESTS(4)) bus ();

  command_credit_scheduler #(.NUM_REQUESTS(4), .CREDIT_W(8)) dut (
    .clock             (clock),
    .rstn              (rstn),
    .enabled_in        (enabled_in),
    .credits_init      (credits_init),
    .cmd_if            (bus),
    .credits_available (credits_available),
    .outstanding       (outstanding),
    .credit_error      (credit_error),
    .drained           (drained),
    .issue_count       (issue_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_issue(input int n);
    return ISSUE_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bring_up(input logic [7:0] c);
    rstn = 1'b0; enabled_in = 1'b1; credits_init = c;
    bus.requests = '0; bus.credit_return = 1'b0;
    step(2);
    rstn = 1'b1;
    step(2);
  endtask

  task automatic load_lines();
    for (int i = 0; i < 4; i++) begin
      lines[i] = '{valid: 1'b1, cmd: 8'(8'h10 + i),
                   command: (i % 2 == 1) ? WRITE_NA : READ_CL_NA,
                   address: 64'h1000_0000 + 64'(i) * 64'h80,
                   size: 12'(64 * (i + 1)), abt: abt_t'(3'(i))};
      bus.command_buffer_in[i] = lines[i];
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled_in = 1'b1; credits_init = 8'd4;
    bus.requests = '0; bus.credit_return = 1'b0;
    step(2);
    n_checks++; if (bus.command_arbiter_out !== CMD_LINE_RESET) begin n_bad++; $display("FAIL reset_out: got %h want %h", bus.command_arbiter_out, CMD_LINE_RESET); end
    n_checks++; if (bus.ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", bus.ready); end
    n_checks++; if (credits_available !== 8'd0) begin n_bad++; $display("FAIL reset_credits: got %0d want 0", credits_available); end
    n_checks++; if (outstanding !== 8'd0) begin n_bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    n_checks++; if (credit_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", credit_error); end
    n_checks++; if (drained !== 1'b1) begin n_bad++; $display("FAIL reset_drained: got %b want 1", drained); end
    n_checks++; if (issue_count !== 32'd0) begin n_bad++; $display("FAIL reset_issue: got %0d want 0", issue_count); end
    rstn = 1'b1;
    step(1);
    n_checks++; if (drained !== 1'b0) begin n_bad++; $display("FAIL init_drained: got %b want 0", drained); end
    n_checks++; if (credits_available !== 8'd0) begin n_bad++; $display("FAIL init_credits: got %0d want 0", credits_available); end
    step(1);
    n_checks++; if (credits_available !== 8'd4) begin n_bad++; $display("FAIL run_credits: got %0d want 4", credits_available); end
    n_checks++; if (bus.command_arbiter_out.valid !== 1'b0) begin n_bad++; $display("FAIL run_idle_valid: got %b want 0", bus.command_arbiter_out.valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    bring_up(8'd16);
    bus.requests = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_r = 4'(1 << (k % 4));
      settle();
      n_checks++; if (bus.ready !== exp_r) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.ready, exp_r); end
      step(1);
      n_checks++; if (bus.command_arbiter_out !== lines[k % 4]) begin n_bad++; $display("FAIL rr_out[%0d]: got %h want %h", k, bus.command_arbiter_out, lines[k % 4]); end
    end
    n_checks++; if (credits_available !== 8'd8) begin n_bad++; $display("FAIL rr_credits: got %0d want 8", credits_available); end
    n_checks++; if (outstanding !== 8'd8) begin n_bad++; $display("FAIL rr_outstanding: got %0d want 8", outstanding); end
    n_checks++; if (issue_count !== exp_issue(8)) begin n_bad++; $display("FAIL rr_issue: got %0d want %0d", issue_count, exp_issue(8)); end
    bus.requests = 4'b0000;
    settle();
    n_checks++; if (bus.ready !== 4'b0000) begin n_bad++; $display("FAIL rr_noreq_ready: got %b want 0000", bus.ready); end
    step(1);
    n_checks++; if (bus.command_arbiter_out !== CMD_LINE_RESET) begin n_bad++; $display("FAIL rr_noreq_out: got %h want %h", bus.command_arbiter_out, CMD_LINE_RESET); end
  endtask

  task automatic test_sparse();
    logic [3:0] reqs [5] = '{4'b1010, 4'b1010, 4'b1010, 4'b0100, 4'b0001};
    int         wins [5] = '{1, 3, 1, 2, 0};
    bring_up(8'd8);
    for (int k = 0; k < 5; k++) begin
      bus.requests = reqs[k];
      settle();
      n_checks++; if (bus.ready !== 4'(1 << wins[k])) begin n_bad++; $display("FAIL sparse_ready[%0d]: got %b want %b", k, bus.ready, 4'(1 << wins[k])); end
      step(1);
      n_checks++; if (bus.command_arbiter_out !== lines[wins[k]]) begin n_bad++; $display("FAIL sparse_out[%0d]: got %h want %h", k, bus.command_arbiter_out, lines[wins[k]]); end
    end
    bus.requests = 4'b0000;
    n_checks++; if (credits_available !== 8'd3) begin n_bad++; $display("FAIL sparse_credits: got %0d want 3", credits_available); end
  endtask

  task automatic test_credit_exhaustion();
    logic [3:0] exp_r [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    bring_up(8'd2);
    bus.requests = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++; if (bus.ready !== exp_r[k]) begin n_bad++; $display("FAIL exh_ready[%0d]: got %b want %b", k, bus.ready, exp_r[k]); end
      step(1);
    end
    n_checks++; if (credits_available !== 8'd0) begin n_bad++; $display("FAIL exh_credits: got %0d want 0", credits_available); end
    n_checks++; if (outstanding !== 8'd2) begin n_bad++; $display("FAIL exh_outstanding: got %0d want 2", outstanding); end
    bus.credit_return = 1'b1;
    settle();
    n_checks++; if (bus.ready !== 4'b0000) begin n_bad++; $display("FAIL exh_ret_ready: got %b want 0000", bus.ready); end
    step(1);
    bus.credit_return = 1'b0;
    n_checks++; if (credits_available !== 8'd1) begin n_bad++; $display("FAIL exh_ret_credits: got %0d want 1", credits_available); end
    settle();
    n_checks++; if (bus.ready !== 4'b0001) begin n_bad++; $display("FAIL exh_regrant_ready: got %b want 0001", bus.ready); end
    step(1);
    n_checks++; if (bus.command_arbiter_out !== lines[0]) begin n_bad++; $display("FAIL exh_regrant_out: got %h want %h", bus.command_arbiter_out, lines[0]); end
    n_checks++; if (outstanding !== 8'd2) begin n_bad++; $display("FAIL exh_regrant_outst: got %0d want 2", outstanding); end
    settle();
    n_checks++; if (bus.ready !== 4'b0000) begin n_bad++; $display("FAIL exh_final_ready: got %b want 0000", bus.ready); end
    bus.requests = 4'b0000;
  endtask

  task automatic test_simultaneous();
    bring_up(8'd4);
    bus.requests = 4'b0001;
    step(3);
    n_checks++; if (credits_available !== 8'd1) begin n_bad++; $display("FAIL sim_pre_credits: got %0d want 1", credits_available); end
    n_checks++; if (outstanding !== 8'd3) begin n_bad++; $display("FAIL sim_pre_outst: got %0d want 3", outstanding); end
    bus.credit_return = 1'b1;
    settle();
    n_checks++; if (bus.ready !== 4'b0001) begin n_bad++; $display("FAIL sim_ready: got %b want 0001", bus.ready); end
    step(1);
    bus.credit_return = 1'b0;
    bus.requests = 4'b0000;
    n_checks++; if (credits_available !== 8'd1) begin n_bad++; $display("FAIL sim_credits: got %0d want 1", credits_available); end
    n_checks++; if (outstanding !== 8'd3) begin n_bad++; $display("FAIL sim_outst: got %0d want 3", outstanding); end
    n_checks++; if (bus.command_arbiter_out !== lines[0]) begin n_bad++; $display("FAIL sim_out: got %h want %h", bus.command_arbiter_out, lines[0]); end
    n_checks++; if (issue_count !== exp_issue(4)) begin n_bad++; $display("FAIL sim_issue: got %0d want %0d", issue_count, exp_issue(4)); end
  endtask

  task automatic test_drain();
    bring_up(8'd8);
    bus.requests = 4'b0001;
    step(3);
    bus.requests = 4'b0000;
    enabled_in = 1'b0;
    step(2);
    n_checks++; if (outstanding !== 8'd3) begin n_bad++; $display("FAIL drain_outst: got %0d want 3", outstanding); end
    n_checks++; if (drained !== 1'b0) begin n_bad++; $display("FAIL drain_busy: got %b want 0", drained); end
    bus.requests = 4'b1111;
    settle();
    n_checks++; if (bus.ready !== 4'b0000) begin n_bad++; $display("FAIL drain_ready: got %b want 0000", bus.ready); end
    for (int r = 0; r < 3; r++) begin
      bus.credit_return = 1'b1;
      step(1);
      n_checks++; if (outstanding !== 8'(2 - r)) begin n_bad++; $display("FAIL drain_ret[%0d]: got %0d want %0d", r, outstanding, 2 - r); end
    end
    bus.credit_return = 1'b0;
    step(1);
    n_checks++; if (drained !== 1'b1) begin n_bad++; $display("FAIL drain_done: got %b want 1", drained); end
    n_checks++; if (credits_available !== 8'd8) begin n_bad++; $display("FAIL drain_credits: got %0d want 8", credits_available); end
    n_checks++; if (bus.ready !== 4'b0000) begin n_bad++; $display("FAIL drain_idle_ready: got %b want 0000", bus.ready); end
    bus.requests = 4'b0000;
    credits_init = 8'd6;
    enabled_in = 1'b1;
    step(1);
    n_checks++; if (drained !== 1'b1) begin n_bad++; $display("FAIL reen_idle: got %b want 1", drained); end
    step(1);
    n_checks++; if (drained !== 1'b0) begin n_bad++; $display("FAIL reen_init: got %b want 0", drained); end
    step(1);
    n_checks++; if (credits_available !== 8'd6) begin n_bad++; $display("FAIL reen_credits: got %0d want 6", credits_available); end
    n_checks++; if (issue_count !== 32'd0) begin n_bad++; $display("FAIL reen_issue: got %0d want 0", issue_count); end
  endtask

  task automatic test_drain_resume();
    bring_up(8'd4);
    bus.requests = 4'b0001;
    step(2);
    bus.requests = 4'b0000;
    enabled_in = 1'b0;
    step(2);
    credits_init = 8'd9;
    enabled_in = 1'b1;
    step(2);
    n_checks++; if (credits_available !== 8'd2) begin n_bad++; $display("FAIL resume_credits: got %0d want 2", credits_available); end
    n_checks++; if (outstanding !== 8'd2) begin n_bad++; $display("FAIL resume_outst: got %0d want 2", outstanding); end
    bus.requests = 4'b0001;
    settle();
    n_checks++; if (bus.ready !== 4'b0001) begin n_bad++; $display("FAIL resume_ready: got %b want 0001", bus.ready); end
    step(1);
    bus.requests = 4'b0000;
  endtask

  task automatic test_credit_error();
    bring_up(8'd4);
    n_checks++; if (credit_error !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %b want 0", credit_error); end
    bus.credit_return = 1'b1;
    step(1);
    bus.credit_return = 1'b0;
    n_checks++; if (credit_error !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", credit_error); end
    n_checks++; if (credits_available !== 8'd4) begin n_bad++; $display("FAIL err_credits: got %0d want 4", credits_available); end
    n_checks++; if (outstanding !== 8'd0) begin n_bad++; $display("FAIL err_outst: got %0d want 0", outstanding); end
    step(3);
    n_checks++; if (credit_error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", credit_error); end
  endtask

  initial begin
    load_lines();
    test_reset();
    test_round_robin();
    test_sparse();
    test_credit_exhaustion();
    test_simultaneous();
    test_drain();
    test_drain_resume();
    test_credit_error();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/command_credit_scheduler.md
Name: command_credit_scheduler

Overview:
- Credit-aware round-robin scheduler in front of the AFU command path.
- Shares one outgoing command slot among NUM_REQUESTS command buffers, and issues only while CAPI command credits remain.
- Tracks outstanding commands and takes credits back on each response.
- Sequences start-up (credit load) and shutdown (drain outstanding commands) with enabled_in.

Parameters:
- NUM_REQUESTS, 4, number of requesting command buffers (2..16).
- CREDIT_W, 8, width of the credit counter and the outstanding counter.

Ports:
- clock  in  1  system clock
- rstn  in  1  synchronous active-low reset, sampled on posedge clock
- enabled_in  in  1  scheduler enable from AFU control
- credits_init  in  CREDIT_W  credit pool size, sampled in INIT
- command_buffer_in  in  CommandBufferLine[NUM_REQUESTS]  per-requester head command
- requests  in  NUM_REQUESTS  per-requester command pending
- credit_return  in  1  one response received; returns one credit
- command_arbiter_out  out  CommandBufferLine  registered issued command
- ready  out  NUM_REQUESTS  one-hot pop strobe to the granted requester
- credits_available  out  CREDIT_W  current free credits
- outstanding  out  CREDIT_W  commands issued but not yet returned
- credit_error  out  1  sticky; set when a return arrives with outstanding==0
- drained  out  1  high in IDLE while outstanding==0
- issue_count  out  32  issued-command counter (see Optional Feature)

Behaviour:
- Reset, while rstn==0 at posedge:
  - FSM goes to IDLE; credits=0; outstanding=0; RR pointer=0; credit_error=0.
  - command_arbiter_out is cleared: valid=0, cmd=0, command=INVALID, address=0, size=0, abt=STRICT.
  - ready=0; issue_count=0.
- enabled_in is registered once (enabled) before the FSM uses it.
- FSM states:
  - IDLE: ready=0, output invalid. When enabled==1, go to INIT.
  - INIT: one cycle. credits <= credits_init; outstanding is kept. Go to RUN.
  - RUN: arbitrate every cycle. When enabled==0, go to DRAIN.
  - DRAIN: no new grants. Returns are still counted. When outstanding==0, go to IDLE. If enabled==1 returns before that, go straight to RUN with no credit reload.
- Arbitration in RUN:
  - Grant is eligible only if credits>0.
  - Winner is the first set bit of requests, searching upward from RR pointer with wrap-around.
  - ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On a grant, RR pointer <= winner+1 mod NUM_REQUESTS. With no grant the pointer holds.
- Output:
  - command_arbiter_out <= command_buffer_in[winner] on the grant cycle. Latency is one cycle from ready to valid.
  - With no grant, the output is cleared to the reset value (valid=0).
- Counters on the same cycle:
  - Grant only: credits-1, outstanding+1.
  - Return only: credits+1, outstanding-1.
  - Grant and return together: both counters unchanged.
- Boundaries:
  - credits==0: no grant, even with requests pending. A return in that cycle makes a grant possible next cycle.
  - A return with outstanding==0 is ignored for the counters and sets credit_error.
  - Counters never wrap.
- Returns arriving in IDLE or INIT decrement outstanding and do not touch credits.
- Reset asserted mid-operation: outstanding is discarded, with no drain.
- drained = (state==IDLE) && (outstanding==0).

Optional Feature:
- Macro CMD_SCHED_ISSUE_COUNT_EN.
- Defined:
  - issue_count increments on every grant, wrapping at 2^32.
  - It is cleared by reset or on entry to INIT.
- Undefined: issue_count is tied to 0 and no counter logic is built.

Test Plan:
- Enable reset recovery: rstn low for 2 cycles, credits_init=4, enabled_in=1 → INIT at cycle 2, RUN at cycle 3, credits_available=4, all outputs at reset values before that.
- Round-robin fairness: credits_init=16, requests=4'b1111 held → grants 0,1,2,3,0,… with ready one-hot; each command_arbiter_out payload equals its requester's line one cycle later.
- Credit exhaustion: credits_init=2, requests=4'b0001 held, no returns → exactly 2 grants, then ready=0. One credit_return → exactly one more grant on the following cycle.
- Simultaneous grant and return: credits=1, outstanding=3, grant and credit_return in the same cycle → credits stays 1, outstanding stays 3.
- Drain: outstanding=3, enabled_in falls → no grants. After 3 returns, IDLE and drained=1. Re-enabling then reloads credits_init.
- Error and macro check:
  - A credit_return with outstanding==0 → credit_error=1 and stays set; counters unchanged.
  - With CMD_SCHED_ISSUE_COUNT_EN defined, issue_count equals the total number of grants; without the macro it stays 0.
